// File: rtl/lfsr_range_gen_if.sv
// Request/valid handshake bundle for lfsr_range_gen ranged draws.
// master = requester (lo/hi/req), slave = generator (busy/valid/value/fallback).
interface lfsr_range_gen_if #(
  parameter int OUT_W = 8
);
  logic             req;
  logic [OUT_W-1:0] lo;
  logic [OUT_W-1:0] hi;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             fallback;

  modport master (
    output req, lo, hi,
    input  busy, valid, value, fallback
  );

  modport slave (
    input  req, lo, hi,
    output busy, valid, value, fallback
  );
endinterface

// File: rtl/lfsr_range_gen.sv
// XNOR Fibonacci LFSR with seed load, lock-up sanitising and a ranged draw
// by rejection sampling, falling back to lo after MAX_TRIES rejections.
//
// state  | meaning
// S_IDLE | waiting for req; LFSR advances only on i_step_en
// S_DRAW | one candidate checked per cycle; LFSR advances every cycle
module lfsr_range_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 'h1D,
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step_en,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_lockup,
  output logic [WIDTH-1:0] o_raw,
  lfsr_range_gen_if.slave  bus
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  state_t           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [OUT_W-1:0] r_lo;
  logic [OUT_W-1:0] r_hi;
  logic [TRY_W-1:0] r_tries;
  logic             r_busy;
  logic             r_valid;
  logic [OUT_W-1:0] r_value;
  logic             r_fallback;
  logic             r_lockup;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [OUT_W-1:0] w_cand;
  logic             w_in_range;

  assign w_fb       = ~^(r_state & TAPS);
  assign w_next     = {w_fb, r_state[WIDTH-1:1]};
  assign w_cand     = r_state[OUT_W-1:0];
  assign w_in_range = (w_cand >= r_lo) && (w_cand <= r_hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_state    <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_tries    <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_value    <= '0;
      r_fallback <= 1'b0;
      r_lockup   <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_fallback <= 1'b0;
      r_lockup   <= 1'b0;

      // All-ones is a fixed point of XNOR feedback, so it is never let in.
      if (i_seed_load) begin
        if (i_seed == ALL_ONES) begin
          r_state  <= '0;
          r_lockup <= 1'b1;
        end else begin
          r_state <= i_seed;
        end
      end else if (r_state == ALL_ONES) begin
        r_state  <= '0;
        r_lockup <= 1'b1;
      end else if (i_step_en || (r_fsm == S_DRAW)) begin
        r_state <= w_next;
      end

      case (r_fsm)
        S_IDLE: begin
          if (bus.req) begin
            r_lo    <= bus.lo;
            r_hi    <= bus.hi;
            r_tries <= '0;
            if (bus.lo > bus.hi) begin
              r_valid    <= 1'b1;
              r_value    <= bus.lo;
              r_fallback <= 1'b1;
            end else begin
              r_fsm  <= S_DRAW;
              r_busy <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (w_in_range) begin
            r_valid <= 1'b1;
            r_value <= w_cand;
            r_fsm   <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tries == LAST_TRY) begin
            r_valid    <= 1'b1;
            r_value    <= r_lo;
            r_fallback <= 1'b1;
            r_fsm      <= S_IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_tries <= r_tries + TRY_W'(1);
          end
        end
        default: begin
          r_fsm  <= S_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.value    = r_value;
  assign bus.fallback = r_fallback;
  assign o_lockup     = r_lockup;
  assign o_raw        = r_state;

endmodule
